// File: rtl/ps2_kbd_source.sv
// ps2_kbd_source: PS/2 set-2 keyboard receiver folding E0/F0 prefixes into toggle-strobed event words
// clk_sys, RESET (sync, active-high); ps2_clk, ps2_data: async PS/2 pins, receive only
// kbd_strobe: toggles per event; kbd_data: {make, extended, scancode}; frame_err: 1-cycle error pulse
module ps2_kbd_source #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kbd_strobe,
  output logic [9:0] kbd_data,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [1:0] clk_ff, dat_ff;
  logic fclk;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bitn, skip;
  logic [7:0] sh;
  logic par, ext, brk;
  logic fall, d, tmo, stop_fall, byte_ok, err;
  // fall fires on the sample that completes FILTER_LEN consecutive lows against a high filtered clock
  assign fall = fclk & ~clk_ff[1] & (fcnt == FW'(FILTER_LEN - 1));
  assign d = dat_ff[1];
  // a fall arriving on the same cycle as the limit restarts the bit timer instead of aborting
  assign tmo = (state != IDLE) & (tcnt == TW'(TIMEOUT_CYCLES - 1)) & ~fall;
  assign stop_fall = fall & (state == STOP);
  assign byte_ok = stop_fall & (^{sh, par}) & d;
  assign err = tmo | (stop_fall & ~byte_ok);
  always_comb begin
    state_n = tmo ? IDLE : !fall ? state :
              state == IDLE   ? (d ? IDLE : DATA) :
              state == DATA   ? (bitn == 3'd7 ? PARITY : DATA) :
              state == PARITY ? STOP : IDLE;
  end
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      clk_ff <= 2'b11;
      dat_ff <= 2'b11;
      fclk <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_ff <= {clk_ff[0], ps2_clk};
      dat_ff <= {dat_ff[0], ps2_data};
      if (clk_ff[1] == fclk) fcnt <= '0;
      else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fclk <= clk_ff[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state <= IDLE;
      tcnt <= '0;
      bitn <= '0;
      sh <= '0;
      par <= 1'b0;
      ext <= 1'b0;
      brk <= 1'b0;
      skip <= '0;
      kbd_strobe <= 1'b0;
      kbd_data <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      frame_err <= err;
      tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) bitn <= '0;
      if (fall && state == DATA) begin
        sh <= {d, sh[7:1]};
        bitn <= bitn + 1'b1;
      end
      if (fall && state == PARITY) par <= d;
      if (err) begin
        ext <= 1'b0;
        brk <= 1'b0;
        skip <= '0;
      end else if (byte_ok) begin
        if (skip != 3'd0) skip <= skip - 1'b1;
        else if (sh == 8'hE1) skip <= 3'd7;
        else if (sh == 8'hE0) ext <= 1'b1;
        else if (sh == 8'hF0) brk <= 1'b1;
        else if (!(sh inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
          kbd_data <= {~brk, ext, sh};
          kbd_strobe <= ~kbd_strobe;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_kbd_source.sv
// tb_ps2_kbd_source: directed table, corner sequences and random frames against a frame-level model
module tb_ps2_kbd_source;
  localparam int FL = 8;
  localparam int TO = 1024;
  localparam int HALF = 16;
  logic clk_sys = 1'b0, RESET = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic kbd_strobe, frame_err;
  logic [9:0] kbd_data;
  int vecs = 0, miss = 0, togs = 0, errs = 0;
  logic prev_s = 1'b0;
  ps2_kbd_source #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_strobe(kbd_strobe), .kbd_data(kbd_data), .frame_err(frame_err));
  always #5 clk_sys = ~clk_sys;
  always @(negedge clk_sys) begin
    if (frame_err) errs++;
    if (kbd_strobe !== prev_s) togs++;
    prev_s = kbd_strobe;
  end
  typedef struct {
    logic [7:0] b;
    bit bp;
    bit bs;
    logic [9:0] d;
    int t;
    int e;
  } vec_t;
  vec_t tbl[$];
  bit m_ext, m_brk;
  int m_skip;
  logic [9:0] m_data;
  int m_tog, m_err;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask
  task automatic send(input logic [7:0] b, input bit bp, input bit bs, input int nbits, input int glitch_at);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == glitch_at) begin
        cyc(5); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF - 8);
      end else cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    cyc(4);
    ps2_data = 1'b1;
    cyc(4);
  endtask
  task automatic model(input logic [7:0] b, input bit good);
    if (!good) begin
      m_err++; m_ext = 0; m_brk = 0; m_skip = 0;
    end else if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
      m_data = {~m_brk, m_ext, b}; m_tog++; m_ext = 0; m_brk = 0;
    end
  endtask
  task automatic do_reset();
    RESET = 1'b1; cyc(3); RESET = 1'b0; cyc(2);
  endtask
  initial begin
    int t0, e0;
    logic [7:0] rb;
    bit bp, bs;
    tbl.push_back('{8'h1C, 0, 0, 10'h21C, 1, 0});
    tbl.push_back('{8'hE0, 0, 0, 10'h21C, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 10'h21C, 0, 0});
    tbl.push_back('{8'h75, 0, 0, 10'h175, 1, 0});
    tbl.push_back('{8'h1C, 1, 0, 10'h175, 0, 1});
    tbl.push_back('{8'h1C, 0, 0, 10'h21C, 1, 0});
    tbl.push_back('{8'hF0, 0, 0, 10'h21C, 0, 0});
    tbl.push_back('{8'h1C, 0, 1, 10'h21C, 0, 1});
    tbl.push_back('{8'h1C, 0, 0, 10'h21C, 1, 0});
    tbl.push_back('{8'hAA, 0, 0, 10'h21C, 0, 0});
    tbl.push_back('{8'h29, 0, 0, 10'h229, 1, 0});
    tbl.push_back('{8'hE1, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'h14, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'h77, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'hE1, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'h14, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'h77, 0, 0, 10'h229, 0, 0});
    tbl.push_back('{8'h16, 0, 0, 10'h216, 1, 0});
    tbl.push_back('{8'hE0, 0, 0, 10'h216, 0, 0});
    tbl.push_back('{8'hFA, 0, 0, 10'h216, 0, 0});
    tbl.push_back('{8'h29, 0, 0, 10'h329, 1, 0});
    do_reset();
    chk("reset_data", int'(kbd_data), 0);
    chk("reset_strobe", int'(kbd_strobe), 0);
    chk("reset_err", int'(frame_err), 0);
    for (int i = 0; i < tbl.size(); i++) begin
      t0 = togs; e0 = errs;
      send(tbl[i].b, tbl[i].bp, tbl[i].bs, 11, -1);
      chk($sformatf("tbl%0d_data", i), int'(kbd_data), int'(tbl[i].d));
      chk($sformatf("tbl%0d_tog", i), togs - t0, tbl[i].t);
      chk($sformatf("tbl%0d_err", i), errs - e0, tbl[i].e);
    end
    t0 = togs; e0 = errs;
    send(8'h1C, 0, 0, 5, -1);
    cyc(TO + 10);
    chk("timeout_err", errs - e0, 1);
    chk("timeout_tog", togs - t0, 0);
    send(8'h29, 0, 0, 11, -1);
    chk("after_timeout_data", int'(kbd_data), 10'h229);
    chk("after_timeout_tog", togs - t0, 1);
    t0 = togs; e0 = errs;
    ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(20);
    send(8'h1C, 0, 0, 11, 4);
    chk("glitch_data", int'(kbd_data), 10'h21C);
    chk("glitch_tog", togs - t0, 1);
    chk("glitch_err", errs - e0, 0);
    send(8'h29, 0, 0, 5, -1);
    RESET = 1'b1; cyc(2);
    #1;
    chk("midreset_data", int'(kbd_data), 0);
    chk("midreset_strobe", int'(kbd_strobe), 0);
    chk("midreset_err", int'(frame_err), 0);
    RESET = 1'b0; cyc(4);
    t0 = togs; e0 = errs;
    send(8'h1C, 0, 0, 11, -1);
    chk("postreset_data", int'(kbd_data), 10'h21C);
    chk("postreset_strobe", int'(kbd_strobe), 1);
    chk("postreset_err", errs - e0, 0);
    do_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_data = '0; m_tog = togs; m_err = errs;
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 5))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: rb = 8'($urandom);
      endcase
      if ($urandom_range(0, 30) == 0) rb = 8'hE1;
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 15) == 0);
      send(rb, bp, bs, 11, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
      model(rb, !(bp || bs));
      chk($sformatf("rnd%0d_data", i), int'(kbd_data), int'(m_data));
      chk($sformatf("rnd%0d_tog", i), togs, m_tog);
      chk($sformatf("rnd%0d_err", i), errs, m_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
